// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler: round-robin ADC sampler that writes per-channel ring
// buffers through RAM port B and shares that port with a display read path.
// Optional build macro: ADC_SAMPLE_AVG_EN -- average 2^AVG_LOG2 captures per
// channel before each RAM write (default build writes every capture raw).

// Per-channel state: ring-buffer write pointer and (optionally) the averager.
module adc_ch_lane #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 640,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cap_en,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] sample,
  output logic [9:0]        ptr,
  output logic              last_slot,
  output logic              out_rdy,
  output logic [DATA_W-1:0] out_val
);
  logic [9:0] ptr_q, ptr_d;

  if (AVG_LOG2 < 0 || AVG_LOG2 > 16) begin : g_bad_avg
    $error("adc_ch_lane: AVG_LOG2 must be 0..16");
  end

  assign ptr       = ptr_q;
  assign last_slot = (ptr_q == 10'(DEPTH - 1));

  // ring pointer advances once per committed write, wrapping at DEPTH-1
  always_comb begin
    ptr_d = ptr_q;
    if (wr_en) ptr_d = last_slot ? 10'd0 : ptr_q + 10'd1;
  end

  // pointer register
  always_ff @(posedge clock) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

`ifdef ADC_SAMPLE_AVG_EN
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int N_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic [N_W-1:0]   n_q, n_d;
  logic             last_cap;

  // the sum includes the sample being captured now, so the last capture's
  // average is available in the same CAPTURE cycle
  assign sum      = acc_q + ACC_W'(sample);
  assign last_cap = (n_q == N_W'((1 << AVG_LOG2) - 1));
  assign out_rdy  = cap_en & last_cap;
  assign out_val  = DATA_W'(sum >> AVG_LOG2);

  // accumulate captures; restart the window after the last one
  always_comb begin
    acc_d = acc_q;
    n_d   = n_q;
    if (cap_en) begin
      acc_d = last_cap ? '0 : sum;
      n_d   = last_cap ? '0 : n_q + 1'b1;
    end
  end

  // accumulator registers
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
      n_q   <= '0;
    end else begin
      acc_q <= acc_d;
      n_q   <= n_d;
    end
  end
`else
  // every capture is written raw
  assign out_rdy = cap_en;
  assign out_val = sample;
`endif
endmodule

module adc_sample_scheduler #(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 12,
  parameter int DEPTH     = 640,
  parameter int BASE_ADDR = 'h800,
  parameter int INTERVAL  = 125000,
  parameter int AVG_LOG2  = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [ADDR_W-1:0]      vga_addr,
  output logic [DATA_W-1:0]      vga_data,
  output logic                   vga_valid,
  output logic                   ram_we,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_din,
  input  logic [DATA_W-1:0]      ram_dout,
  output logic [NUM_CH*10-1:0]   wr_ptr,
  output logic [NUM_CH-1:0]      frame_done,
  output logic                   sample_tick
);
  localparam int CNT_W = $clog2(INTERVAL);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_ch
    $error("adc_sample_scheduler: NUM_CH must be 1..8");
  end
  if (DEPTH < 2 || DEPTH > 1024) begin : g_bad_depth
    $error("adc_sample_scheduler: DEPTH must be 2..1024");
  end
  if (INTERVAL < 4) begin : g_bad_int
    $error("adc_sample_scheduler: INTERVAL must be >= 4");
  end
  if (longint'(BASE_ADDR) + longint'(NUM_CH) * DEPTH > (longint'(1) << ADDR_W)) begin : g_bad_map
    $error("adc_sample_scheduler: channel regions exceed the ADDR_W address space");
  end

  typedef enum logic [1:0] {IDLE, CAPTURE, WRITE} state_e;

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [SEL_W-1:0]               sel_q, sel_d, cs_q, cs_d;
  logic [DATA_W-1:0]              smp_q, smp_d;
  logic                           vga_valid_q, vga_valid_d;
  logic                           tick;
  logic [NUM_CH-1:0]              cap_vec, wr_vec, lane_last, lane_rdy;
  logic [NUM_CH-1:0][9:0]         lane_ptr;
  logic [NUM_CH-1:0][DATA_W-1:0]  lane_val;
  logic [ADDR_W-1:0]              wr_addr;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    adc_ch_lane #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AVG_LOG2(AVG_LOG2)) u_lane (
      .clock     (clock),
      .reset     (reset),
      .cap_en    (cap_vec[c]),
      .wr_en     (wr_vec[c]),
      .sample    (ch_data[c*DATA_W +: DATA_W]),
      .ptr       (lane_ptr[c]),
      .last_slot (lane_last[c]),
      .out_rdy   (lane_rdy[c]),
      .out_val   (lane_val[c])
    );
  end

  // tick counter: holds while disabled, wraps to 0 after the tick
  always_comb begin
    tick  = enable && (cnt_q == CNT_W'(INTERVAL - 1));
    cnt_d = cnt_q;
    if (enable) cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // sampling FSM; cs_q pins the channel for the whole capture/write so the
  // round-robin selector can advance at the tick. INTERVAL >= 4 guarantees
  // the next tick only arrives back in IDLE.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cs_d    = cs_q;
    smp_d   = smp_q;
    cap_vec = '0;
    wr_vec  = '0;
    case (state_q)
      IDLE: if (tick) begin
        state_d = CAPTURE;
        cs_d    = sel_q;
        sel_d   = (sel_q == SEL_W'(NUM_CH - 1)) ? '0 : sel_q + 1'b1;
      end
      CAPTURE: begin
        cap_vec[cs_q] = 1'b1;
        smp_d         = lane_val[cs_q];
        state_d       = lane_rdy[cs_q] ? WRITE : IDLE;
      end
      WRITE: begin
        wr_vec[cs_q] = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // display data returns one cycle after its address; a write cycle steals it
  always_comb vga_valid_d = (state_q != WRITE);

  // state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      cs_q        <= '0;
      smp_q       <= '0;
      vga_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      cs_q        <= cs_d;
      smp_q       <= smp_d;
      vga_valid_q <= vga_valid_d;
    end
  end

  assign wr_addr     = ADDR_W'(BASE_ADDR) + ADDR_W'(int'(cs_q) * DEPTH) + ADDR_W'(lane_ptr[cs_q]);
  assign ram_we      = (state_q == WRITE);
  assign ram_addr    = ram_we ? wr_addr : vga_addr;
  assign ram_din     = smp_q;
  assign frame_done  = wr_vec & lane_last;
  assign wr_ptr      = lane_ptr;
  assign sample_tick = tick;
  assign vga_data    = ram_dout;
  assign vga_valid   = vga_valid_q;
endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Scoreboard bench for adc_sample_scheduler (NUM_CH=2, DEPTH=4, INTERVAL=8).
// Cycle numbering: cycle 0 is the first cycle with reset low.
module tb_adc_sample_scheduler;
  logic        clk = 1'b0;
  logic        reset, enable, vga_valid, ram_we, sample_tick;
  logic [63:0] ch_data;
  logic [11:0] vga_addr, ram_addr;
  logic [31:0] vga_data, ram_din, ram_dout;
  logic [19:0] wr_ptr;
  logic [1:0]  frame_done;

  adc_sample_scheduler #(
    .NUM_CH(2), .DATA_W(32), .ADDR_W(12), .DEPTH(4),
    .BASE_ADDR('h800), .INTERVAL(8), .AVG_LOG2(2)
  ) dut (
    .clock(clk), .reset(reset), .enable(enable), .ch_data(ch_data),
    .vga_addr(vga_addr), .vga_data(vga_data), .vga_valid(vga_valid),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .wr_ptr(wr_ptr), .frame_done(frame_done), .sample_tick(sample_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [31:0] data;
    logic [1:0]  fd;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [11:0] a, input logic [31:0] d, input logic [1:0] f);
    sb.push_back('{c, a, d, f});
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // monitor: pops the expected write when its cycle comes up, otherwise
  // checks that port B carries the display address
  logic mon_we, we_prev = 1'b0, rst_prev = 1'b1;
  exp_t mon_e;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      mon_e = sb.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL missed_write: got none, expected 0x%0h@0x%0h at cycle %0d", mon_e.data, mon_e.addr, mon_e.cyc);
    end
    mon_we = 1'b0;
    if (sb.size() > 0) mon_we = (sb[0].cyc == cyc);
    chk("ram_we", ram_we, mon_we);
    if (mon_we) begin
      mon_e = sb.pop_front();
      chk("write_addr", ram_addr, mon_e.addr);
      chk("write_data", ram_din, mon_e.data);
      chk("frame_done", frame_done, mon_e.fd);
    end else begin
      chk("vga_arb_addr", ram_addr, vga_addr);
      chk("frame_done_idle", frame_done, 0);
    end
    chk("vga_valid", vga_valid, (rst_prev || we_prev) ? 0 : 1);
    we_prev  = mon_we;
    rst_prev = reset;
  end

  int c0, c1, c2, bad;

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    ch_data  = {32'h22, 32'h11};
    vga_addr = 12'h900;
    ram_dout = 32'h5A5A_1234;

    // reset state
    goto_cyc(2);
    @(negedge clk);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_wr_ptr", wr_ptr, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_sample_tick", sample_tick, 0);
    chk("rst_vga_valid", vga_valid, 0);
    chk("rst_ram_addr", ram_addr, 12'h900);
    chk("vga_data", vga_data, 32'h5A5A_1234);

`ifndef ADC_SAMPLE_AVG_EN
    // run + wrap: ticks at 7+8j, writes two cycles later, channels alternate
    goto_cyc(cyc + 1);
    reset = 1'b0;
    c0 = cyc;
    push(c0 + 9,  12'h800, 32'h11, 2'b00);
    push(c0 + 17, 12'h804, 32'h22, 2'b00);
    push(c0 + 25, 12'h801, 32'h11, 2'b00);
    push(c0 + 33, 12'h805, 32'h22, 2'b00);
    push(c0 + 41, 12'h802, 32'h11, 2'b00);
    push(c0 + 49, 12'h806, 32'h22, 2'b00);
    push(c0 + 57, 12'h803, 32'h11, 2'b01);
    push(c0 + 65, 12'h807, 32'h22, 2'b10);
    push(c0 + 73, 12'h800, 32'h11, 2'b00);
    push(c0 + 81, 12'h804, 32'h22, 2'b00);
    ram_dout = 32'h0BAD_F00D;

    // reset asserted during the WRITE cycle at c0+81
    goto_cyc(c0 + 81);
    reset = 1'b1;
    goto_cyc(c0 + 82);
    reset = 1'b0;
    c1 = cyc;
    @(negedge clk);
    chk("abort_ram_we", ram_we, 0);
    chk("abort_wr_ptr", wr_ptr, 0);
    push(c1 + 9,  12'h800, 32'h11, 2'b00);
    push(c1 + 17, 12'h804, 32'h22, 2'b00);
    push(c1 + 45, 12'h801, 32'h11, 2'b00);

    // enable low for 20 cycles at count 5; counter resumes 5,6,7
    goto_cyc(c1 + 21);
    enable = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (sample_tick) bad++;
    end
    chk("tick_while_disabled", bad, 0);
    goto_cyc(c1 + 41);
    enable = 1'b1;
    @(negedge clk);
    chk("tick_resume_cnt5", sample_tick, 0);
    @(negedge clk);
    chk("tick_resume_cnt6", sample_tick, 0);
    @(negedge clk);
    chk("tick_resume_cnt7", sample_tick, 1);

    // reset during the ch1 CAPTURE at c1+52: that write must never appear
    goto_cyc(c1 + 52);
    reset = 1'b1;
`endif

    // averaging / raw-write test
    goto_cyc(cyc + 1);
    ch_data = {32'h22, 32'd4};
    reset   = 1'b0;
    c2 = cyc;
    @(negedge clk);
    chk("post_reset_ram_we", ram_we, 0);
`ifdef ADC_SAMPLE_AVG_EN
    push(c2 + 57, 12'h800, 32'd10,  2'b00);
    push(c2 + 65, 12'h804, 32'h22,  2'b00);
`else
    push(c2 + 9,  12'h800, 32'd4,  2'b00);
    push(c2 + 17, 12'h804, 32'h22, 2'b00);
    push(c2 + 25, 12'h801, 32'd8,  2'b00);
    push(c2 + 33, 12'h805, 32'h22, 2'b00);
    push(c2 + 41, 12'h802, 32'd12, 2'b00);
    push(c2 + 49, 12'h806, 32'h22, 2'b00);
    push(c2 + 57, 12'h803, 32'd16, 2'b01);
    push(c2 + 65, 12'h807, 32'h22, 2'b10);
`endif
    goto_cyc(c2 + 9);
    ch_data[31:0] = 32'd8;
    goto_cyc(c2 + 25);
    ch_data[31:0] = 32'd12;
    goto_cyc(c2 + 41);
    ch_data[31:0] = 32'd16;

    goto_cyc(c2 + 70);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_sample_scheduler.md
ADC_SAMPLE_SCHEDULER -- requirements
Module: adc_sample_scheduler

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter NUM_CH, 2, number of ADC channels sampled round-robin (1..8).
REQ-002 The block SHALL have parameter DATA_W, 32, sample and RAM word width.
REQ-003 The block SHALL have parameter ADDR_W, 12, RAM port B address width.
REQ-004 The block SHALL have parameter DEPTH, 640, samples per channel ring buffer (2..1024).
REQ-005 The block SHALL have parameter BASE_ADDR, 12'h800, address of channel 0 slot 0; channel c region starts at BASE_ADDR + c*DEPTH.
REQ-006 The block SHALL have parameter INTERVAL, 125000, clock cycles between sample ticks (>= 4).
REQ-007 The block SHALL have parameter AVG_LOG2, 2, log2 of samples averaged per write (used only under REQ-030).
Ports (name, direction, width, meaning):
REQ-008 The block SHALL have port clock, input, 1, single clock; all logic on its rising edge.
REQ-009 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-010 The block SHALL have port enable, input, 1, sampling enable.
REQ-011 The block SHALL have port ch_data, input, NUM_CH*DATA_W, channel samples; channel c at bits [c*DATA_W +: DATA_W].
REQ-012 The block SHALL have port vga_addr, input, ADDR_W, display read address.
REQ-013 The block SHALL have ports vga_data (output, DATA_W, read data) and vga_valid (output, 1, vga_data valid).
REQ-014 The block SHALL have ports ram_we (output, 1), ram_addr (output, ADDR_W), ram_din (output, DATA_W) and ram_dout (input, DATA_W), driving RAM port B with a 1-cycle read latency.
REQ-015 The block SHALL have ports wr_ptr (output, NUM_CH*10, next slot per channel), frame_done (output, NUM_CH, wrap pulse) and sample_tick (output, 1, tick pulse).

Function
REQ-016 The tick counter SHALL count 0..INTERVAL-1 while enable=1; sample_tick SHALL be high for one cycle at count INTERVAL-1, after which the counter returns to 0.
REQ-017 When enable=0, the counter SHALL hold its value, no new tick SHALL be issued, and an in-progress capture/write SHALL complete.
REQ-018 The channel selector SHALL start at 0 and advance modulo NUM_CH after each tick.
REQ-019 The FSM SHALL have states IDLE -> CAPTURE (on tick) -> WRITE -> IDLE, with one cycle in each of CAPTURE and WRITE.
REQ-020 CAPTURE SHALL latch the selected channel's sample; in WRITE, ram_we=1, ram_addr = BASE_ADDR + sel*DEPTH + wr_ptr[sel], and ram_din = the latched sample.
REQ-021 Write latency SHALL be: tick in cycle T, ram_we=1 in cycle T+2.
REQ-022 wr_ptr[sel] SHALL increment after each write and wrap from DEPTH-1 to 0; frame_done[sel] SHALL pulse in the same cycle as the write to slot DEPTH-1.
REQ-023 Outside WRITE, ram_addr SHALL equal vga_addr and ram_we SHALL be 0.
REQ-024 vga_data SHALL equal ram_dout, and vga_valid SHALL be 1 in the cycle after a non-WRITE cycle and 0 in the cycle after WRITE.
REQ-025 Address arithmetic SHALL be done at ADDR_W width; configurations whose regions exceed 2^ADDR_W are illegal and SHALL be flagged by an elaboration-time check.

Reset
REQ-026 On reset, the counter, selector, all wr_ptr, frame_done, sample_tick, ram_we and vga_valid SHALL go to 0 and the FSM to IDLE at the next edge.
REQ-027 Reset asserted during CAPTURE or WRITE SHALL abort the operation: ram_we=0 in the cycle after the reset edge, with no pointer update.
REQ-028 After reset deasserts, the first tick SHALL occur INTERVAL cycles later (with enable=1).
REQ-029 Averaging accumulators (REQ-030) SHALL also clear to 0 on reset.

Configuration
REQ-030 With ADC_SAMPLE_AVG_EN defined, each channel SHALL accumulate 2^AVG_LOG2 captured samples in a (DATA_W+AVG_LOG2)-bit register and write sum>>AVG_LOG2 (truncated) only on the last capture, with CAPTURE-only ticks skipping WRITE; without the macro, every capture SHALL be written raw and AVG_LOG2 SHALL be ignored.

Verification
(Config unless stated: NUM_CH=2, DEPTH=4, INTERVAL=8, BASE_ADDR=0x800.)
REQ-031 Run test: ch0=0x11, ch1=0x22, enable=1 after reset -> ram_we at cycles 9 and 17; writes are 0x11@0x800, then 0x22@0x804.
REQ-032 Wrap test: 5 ch0 writes -> addresses 0x800, 0x801, 0x802, 0x803, 0x800; frame_done[0] pulses with the 0x803 write.
REQ-033 Arbitration test: vga_addr=0x900 held -> ram_addr=0x900 except in WRITE cycles; vga_valid low only in the cycle after each WRITE.
REQ-034 Reset test: reset asserted in a WRITE cycle -> next cycle ram_we=0, wr_ptr=0, and the next write goes to 0x800.
REQ-035 Enable test: enable=0 for 20 cycles at count 5 -> no tick; the tick fires 3 cycles after enable returns.
REQ-036 Averaging test (macro on, AVG_LOG2=2): ch0 samples 4, 8, 12, 16 -> a single write of 10 to 0x800 after the 4th ch0 capture; with the macro off, four writes of 4, 8, 12, 16.
